// File: rtl/gpu_pkg.sv
// Shared rasterizer definitions: tile geometry, pixel format and tile reader state encoding.
package gpu_pkg;

    localparam int unsigned TILE_ROWS_DEF     = 32;
    localparam int unsigned WORDS_PER_ROW_DEF = 16;
    localparam int unsigned TILE_WORDS        = TILE_ROWS_DEF * WORDS_PER_ROW_DEF;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } tile_rd_state_t;

    // Exchange the left and right pixels held in one 32-bit word.
    function automatic logic [31:0] swap_pixels(input logic [31:0] w);
        pixel_t lo;
        pixel_t hi;
        lo = pixel_t'(w[15:0]);
        hi = pixel_t'(w[31:16]);
        return {lo, hi};
    endfunction

endpackage

// File: rtl/tile_reader_rsp_fifo.sv
// Single-clock show-ahead FIFO holding read responses; DEPTH must be a power of two.
module tile_reader_rsp_fifo
    import gpu_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_wr    = i_wr && !o_full;
    assign w_rd    = i_rd && !o_empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tile_reader.sv
// Avalon-MM read master fetching one tile and streaming it out row-major over valid/ready.
// Define TILE_READER_SWAP_EN to swap the two pixels within each output word.
module tile_reader
    import gpu_pkg::*;
#(
    parameter int unsigned TILE_ROWS     = TILE_ROWS_DEF,
    parameter int unsigned WORDS_PER_ROW = WORDS_PER_ROW_DEF,
    parameter int unsigned MAX_PENDING   = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] addr_in,
    input  logic [15:0] stride_in,
    output logic        running_out,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic        master_wait_request,
    input  logic [31:0] master_read_data,
    input  logic        master_read_data_valid,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned WORDS  = TILE_ROWS * WORDS_PER_ROW;
    localparam int unsigned CNT_W  = $clog2(WORDS + 1);
    localparam int unsigned COL_W  = $clog2(WORDS_PER_ROW);
    localparam int unsigned CRED_W = $clog2(MAX_PENDING + 1);

    tile_rd_state_t r_state,     w_state_nxt;
    logic [31:0]    r_row_base,  w_base_nxt;
    logic [15:0]    r_stride,    w_stride_nxt;
    logic [COL_W-1:0] r_col,     w_col_nxt;
    logic [CNT_W-1:0] r_issued,  w_issued_nxt;
    logic [CNT_W-1:0] r_delivered, w_deliv_nxt;
    logic [CRED_W-1:0] r_cred,   w_cred_nxt;
    logic           r_read,      w_read_nxt;
    logic [31:0]    r_addr,      w_addr_nxt;
    logic           r_running;

    logic           w_accept;
    logic           w_hs;
    logic           w_fifo_wr;
    logic           w_fifo_empty;
    logic           w_fifo_full;
    logic [31:0]    w_head;

    assign master_read    = r_read;
    assign master_address = r_addr;
    assign running_out    = r_running;
    assign out_valid      = !w_fifo_empty;

    assign w_accept  = r_read && !master_wait_request;
    assign w_hs      = out_valid && out_ready;
    // Responses arriving while idle are strays from an aborted fetch.
    assign w_fifo_wr = master_read_data_valid && (r_state != ST_IDLE) && !w_fifo_full;

`ifdef TILE_READER_SWAP_EN
    assign out_data = swap_pixels(w_head);
`else
    assign out_data = w_head;
`endif

    tile_reader_rsp_fifo #(
        .DEPTH (MAX_PENDING),
        .WIDTH (32)
    ) u_rsp_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_wr    (w_fifo_wr),
        .i_wdata (master_read_data),
        .i_rd    (w_hs),
        .o_rdata (w_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // Next-state, request and counter logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_base_nxt   = r_row_base;
        w_stride_nxt = r_stride;
        w_col_nxt    = r_col;
        w_issued_nxt = r_issued;
        w_deliv_nxt  = r_delivered;
        w_cred_nxt   = r_cred;
        w_read_nxt   = 1'b0;
        w_addr_nxt   = r_addr;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt  = ST_ISSUE;
                    w_base_nxt   = addr_in;
                    w_stride_nxt = stride_in;
                    w_col_nxt    = '0;
                    w_issued_nxt = '0;
                    w_deliv_nxt  = '0;
                    w_cred_nxt   = '0;
                    w_read_nxt   = 1'b1;
                    w_addr_nxt   = addr_in;
                end
            end
            ST_ISSUE, ST_DRAIN: begin
                if (w_accept) begin
                    w_issued_nxt = r_issued + CNT_W'(1);
                    if (r_col == COL_W'(WORDS_PER_ROW - 1)) begin
                        w_col_nxt  = '0;
                        w_base_nxt = r_row_base + 32'(r_stride);
                    end else begin
                        w_col_nxt  = r_col + COL_W'(1);
                    end
                end
                if (w_hs) begin
                    w_deliv_nxt = r_delivered + CNT_W'(1);
                end
                unique case ({w_accept, w_hs})
                    2'b10:   w_cred_nxt = r_cred + CRED_W'(1);
                    2'b01:   w_cred_nxt = r_cred - CRED_W'(1);
                    default: w_cred_nxt = r_cred;
                endcase

                if (r_state == ST_ISSUE) begin
                    // A stalled request holds; otherwise present the next one if credit allows.
                    if (r_read && master_wait_request) begin
                        w_read_nxt = 1'b1;
                    end else if ((w_issued_nxt != CNT_W'(WORDS)) &&
                                 (w_cred_nxt < CRED_W'(MAX_PENDING))) begin
                        w_read_nxt = 1'b1;
                        w_addr_nxt = w_base_nxt + (32'(w_col_nxt) << 2);
                    end
                    if (w_accept && (r_issued == CNT_W'(WORDS - 1))) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end else if (w_hs && (r_delivered == CNT_W'(WORDS - 1))) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_row_base  <= '0;
            r_stride    <= '0;
            r_col       <= '0;
            r_issued    <= '0;
            r_delivered <= '0;
            r_cred      <= '0;
            r_read      <= 1'b0;
            r_addr      <= '0;
            r_running   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row_base  <= w_base_nxt;
            r_stride    <= w_stride_nxt;
            r_col       <= w_col_nxt;
            r_issued    <= w_issued_nxt;
            r_delivered <= w_deliv_nxt;
            r_cred      <= w_cred_nxt;
            r_read      <= w_read_nxt;
            r_addr      <= w_addr_nxt;
            r_running   <= (w_state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_tile_reader.sv
// Randomized bench for tile_reader: Avalon slave model with random latency/stalls and a tile reference model.
module tb_tile_reader;

    localparam int unsigned WPR  = 16;
    localparam int unsigned NW   = 512;
    localparam int unsigned MAXP = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] addr_in = '0;
    logic [15:0] stride_in = '0;
    logic        running_out;
    logic [31:0] master_address;
    logic        master_read;
    logic        master_wait_request = 1'b0;
    logic [31:0] master_read_data = '0;
    logic        master_read_data_valid = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    always #5 clk = ~clk;

    tile_reader dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .start                  (start),
        .addr_in                (addr_in),
        .stride_in              (stride_in),
        .running_out            (running_out),
        .master_address         (master_address),
        .master_read            (master_read),
        .master_wait_request    (master_wait_request),
        .master_read_data       (master_read_data),
        .master_read_data_valid (master_read_data_valid),
        .out_data               (out_data),
        .out_valid              (out_valid),
        .out_ready              (out_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference tile and slave state
    logic [31:0] exp_base;
    logic [31:0] exp_stride;
    logic [31:0] rsp_data[$];
    int          rsp_due[$];
    logic [31:0] acc_log[NW];
    logic [31:0] first_out;
    int cyc = 0, n_acc = 0, n_del = 0, n_ret = 0, stray_n = 0, bad9 = 0;
    int ready_pct = 100, wait_pct = 0, lat_lo = 1, lat_hi = 1;
    int stall_idx = -1, stall_left = 0;
    bit active = 1'b0, in_fetch = 1'b0;
    bit prev_stall = 1'b0, prev_hold = 1'b0;
    logic [31:0] prev_addr, prev_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'h1234_ABCD;
        return (a * 32'h9E37_79B1) ^ (a >> 7) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] exp_addr(input int k);
        return exp_base + 32'(k / WPR) * exp_stride + 32'(k % WPR) * 32'd4;
    endfunction

    function automatic logic [31:0] exp_out(input logic [31:0] w);
`ifdef TILE_READER_SWAP_EN
        return {w[15:0], w[31:16]};
`else
        return w;
`endif
    endfunction

    // One clock cycle: check current outputs, drive slave/consumer inputs, record handshakes, advance.
    task automatic step();
        bit acc;
        bit hs;
        if (active) begin
            check_eq("out_valid", 32'(out_valid), 32'(n_ret > n_del));
            if (prev_stall) begin
                check_eq("hold_read", 32'(master_read), 32'd1);
                check_eq("hold_addr", master_address, prev_addr);
            end
            if (prev_hold) check_eq("out_stable", out_data, prev_data);
        end
        if (in_fetch) check_eq("running", 32'(running_out), 32'(n_del < int'(NW)));

        master_read_data_valid = 1'b0;
        master_read_data       = '0;
        if (stray_n > 0) begin
            master_read_data_valid = 1'b1;
            master_read_data       = $urandom;
            stray_n--;
        end else if (rsp_data.size() > 0 && rsp_due[0] <= cyc) begin
            master_read_data_valid = 1'b1;
            master_read_data       = rsp_data.pop_front();
            void'(rsp_due.pop_front());
            n_ret++;
        end
        out_ready           = ($urandom_range(0, 99) < ready_pct);
        master_wait_request = ($urandom_range(0, 99) < wait_pct);
        if (active && master_read && n_acc == stall_idx && stall_left > 0) begin
            master_wait_request = 1'b1;
            stall_left--;
            check_eq("stall_addr", master_address, exp_addr(stall_idx));
        end

        acc = master_read && !master_wait_request;
        hs  = out_valid && out_ready;
        if (active && acc) begin
            check_eq("no_extra_read", 32'(n_acc < int'(NW)), 32'd1);
            check_eq("cred_bound", 32'((n_acc - n_del) < int'(MAXP)), 32'd1);
            if (n_acc < int'(NW)) begin
                check_eq("rd_addr", master_address, exp_addr(n_acc));
                acc_log[n_acc] = master_address;
            end
            if (master_address >= 32'h9000 && master_address < 32'h1_9000) bad9++;
            rsp_data.push_back(mem_word(master_address));
            rsp_due.push_back(cyc + int'($urandom_range(lat_lo, lat_hi)));
            n_acc++;
        end
        if (active && hs) begin
            check_eq("no_extra_out", 32'(n_del < int'(NW)), 32'd1);
            if (n_del < int'(NW)) check_eq("out_data", out_data, exp_out(mem_word(exp_addr(n_del))));
            if (n_del == 0) first_out = out_data;
            n_del++;
        end
        prev_stall = active && master_read && master_wait_request;
        prev_addr  = master_address;
        prev_hold  = active && out_valid && !out_ready;
        prev_data  = out_data;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic begin_fetch(input logic [31:0] a, input logic [15:0] s);
        exp_base   = a;
        exp_stride = 32'(s);
        n_acc = 0; n_del = 0; n_ret = 0; bad9 = 0;
        rsp_data.delete();
        rsp_due.delete();
        prev_stall = 1'b0;
        prev_hold  = 1'b0;
        active     = 1'b1;
        addr_in    = a;
        stride_in  = s;
        start      = 1'b1;
        step();
        start     = 1'b0;
        addr_in   = $urandom;
        stride_in = 16'($urandom);
        check_eq("running_rise", 32'(running_out), 32'd1);
        check_eq("first_req", 32'(master_read), 32'd1);
        check_eq("first_addr", master_address, a);
        in_fetch = 1'b1;
    endtask

    task automatic finish_fetch(input string tag);
        int guard;
        guard = 0;
        while (n_del < int'(NW) && guard < 20000) begin
            step();
            guard++;
        end
        check_eq({tag, "_delivered"}, 32'(n_del), NW);
        check_eq({tag, "_accepted"}, 32'(n_acc), NW);
        check_eq({tag, "_run_fall"}, 32'(running_out), 32'd0);
        check_eq({tag, "_read_idle"}, 32'(master_read), 32'd0);
        repeat (4) step();
        in_fetch = 1'b0;
        active   = 1'b0;
    endtask

    initial begin
        int t0;
        int guard;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_read", 32'(master_read), 32'd0);
        check_eq("rst_addr", master_address, 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", out_data, 32'd0);
        check_eq("rst_running", 32'(running_out), 32'd0);
        resetn = 1'b1;
        repeat (2) step();

        // Basic fetch, no stalls
        ready_pct = 100; wait_pct = 0; lat_lo = 2; lat_hi = 2;
        t0 = cyc;
        begin_fetch(32'h0000_1000, 16'd2048);
        finish_fetch("basic");
        check_eq("addr_1st", acc_log[0], 32'h0000_1000);
        check_eq("addr_17th", acc_log[16], 32'h0000_1800);
        check_eq("addr_512th", acc_log[511], 32'h0001_083C);
`ifdef TILE_READER_SWAP_EN
        check_eq("swap_word0", first_out, 32'hABCD_1234);
`else
        check_eq("swap_word0", first_out, 32'h1234_ABCD);
`endif
        check_eq("basic_rate", 32'((cyc - t0) < 540), 32'd1);

        // Backpressure: credit limit
        ready_pct = 0; wait_pct = 0; lat_lo = 2; lat_hi = 2;
        begin_fetch(32'h0000_1000, 16'd2048);
        repeat (20) step();
        check_eq("bp_accepted", 32'(n_acc), 32'd8);
        check_eq("bp_read_low", 32'(master_read), 32'd0);
        ready_pct = 100;
        step();
        ready_pct = 0;
        repeat (10) step();
        check_eq("bp_one_more", 32'(n_acc), 32'd9);
        ready_pct = 60; wait_pct = 20; lat_lo = 1; lat_hi = 6;
        finish_fetch("bp");

        // Wait request held on the 3rd read
        ready_pct = 100; wait_pct = 0; lat_lo = 1; lat_hi = 3;
        stall_idx = 2; stall_left = 5;
        begin_fetch(32'h0000_1000, 16'd2048);
        finish_fetch("wait");
        check_eq("stall_applied", 32'(stall_left), 32'd0);
        check_eq("stall_3rd", acc_log[2], 32'h0000_1008);
        stall_idx = -1;

        // Ignored start mid-fetch
        ready_pct = 70; wait_pct = 15; lat_lo = 1; lat_hi = 5;
        begin_fetch(32'h4000_0000, 16'h0400);
        guard = 0;
        while (n_acc < 200 && guard < 5000) begin step(); guard++; end
        addr_in = 32'h0000_9000;
        start   = 1'b1;
        step();
        start   = 1'b0;
        finish_fetch("ign");
        check_eq("ign_no_9000", 32'(bad9), 32'd0);

        // Reset mid-operation, then stray responses
        ready_pct = 50; wait_pct = 10; lat_lo = 1; lat_hi = 4;
        begin_fetch(32'h0000_1000, 16'd2048);
        guard = 0;
        while (n_acc < 100 && guard < 5000) begin step(); guard++; end
        check_eq("rst_mid_reached", 32'(n_acc), 32'd100);
        resetn = 1'b0;
        #1;
        check_eq("mid_rst_read", 32'(master_read), 32'd0);
        check_eq("mid_rst_addr", master_address, 32'd0);
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_data", out_data, 32'd0);
        check_eq("mid_rst_running", 32'(running_out), 32'd0);
        active = 1'b0; in_fetch = 1'b0;
        rsp_data.delete();
        rsp_due.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        stray_n = 3;
        repeat (6) begin
            step();
            check_eq("stray_valid", 32'(out_valid), 32'd0);
            check_eq("stray_read", 32'(master_read), 32'd0);
        end
        begin_fetch(32'h0000_1000, 16'd2048);
        finish_fetch("post_rst");

        // Randomized fetches, including address wraparound
        for (int r = 0; r < 3; r++) begin
            ready_pct = int'($urandom_range(30, 100));
            wait_pct  = int'($urandom_range(0, 40));
            lat_lo    = int'($urandom_range(1, 3));
            lat_hi    = lat_lo + int'($urandom_range(0, 6));
            if (r == 0) begin_fetch(32'hFFFF_FF00, 16'hFFFF);
            else        begin_fetch($urandom, 16'($urandom));
            finish_fetch("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
